// File: rtl/ram_writeboard.sv
// Nibble-at-a-time word assembler that writes one 32-bit word per eight load events.
// Optional read-back verification is enabled by defining RAM_WRITEBOARD_READBACK_EN.
module ram_writeboard #(
  parameter int unsigned D = 8,
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [D-1:0] addr_i,
  input  logic [3:0]   nibble_i,
  input  logic         load_i,
  input  logic         abort_i,
  output logic         wren_o,
  output logic [D-1:0] waddr_o,
  output logic [W-1:0] wdata_o,
  output logic [2:0]   count_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [6:0]   display_o
`ifdef RAM_WRITEBOARD_READBACK_EN
  ,
  output logic         rden_o,
  input  logic [W-1:0] rdata_i,
  output logic         err_o
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StWrite,
    StVerify,
    StDone
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] word_q, word_d;
  logic [D-1:0] addr_q, addr_d;
  logic [2:0]   count_q, count_d;
  logic [6:0]   disp_q, disp_d;
  logic [W-1:0] wdata_q;
  logic [D-1:0] waddr_q;
  logic         load_prev_q;
  logic         load_evt;
  logic         take;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'ha: seg7 = 7'b0001000;
      4'hb: seg7 = 7'b0000011;
      4'hc: seg7 = 7'b1000110;
      4'hd: seg7 = 7'b0100001;
      4'he: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  assign load_evt = load_i & ~load_prev_q;

`ifdef RAM_WRITEBOARD_READBACK_EN
  logic vphase_q;
  logic err_q;
`endif

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    addr_d  = addr_q;
    count_d = count_q;
    take    = 1'b0;
    case (state_q)
      StIdle: begin
        if (abort_i) begin
          count_d = 3'd0;
          word_d  = '0;
        end else if (load_evt) begin
          word_d  = {{(W-4){1'b0}}, nibble_i};
          addr_d  = addr_i;
          count_d = 3'd1;
          take    = 1'b1;
          state_d = StCollect;
        end
      end
      StCollect: begin
        if (abort_i) begin
          count_d = 3'd0;
          word_d  = '0;
          state_d = StIdle;
        end else if (load_evt) begin
          word_d[{count_q, 2'b00} +: 4] = nibble_i;
          count_d = count_q + 3'd1;
          take    = 1'b1;
          if (count_q == 3'd7) state_d = StWrite;
        end
      end
`ifdef RAM_WRITEBOARD_READBACK_EN
      StWrite:  state_d = StVerify;
      StVerify: state_d = vphase_q ? StDone : StVerify;
`else
      StWrite:  state_d = StDone;
`endif
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    disp_d = take ? seg7(nibble_i) : disp_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      word_q      <= '0;
      addr_q      <= '0;
      count_q     <= 3'd0;
      disp_q      <= 7'b1000000;
      wdata_q     <= '0;
      waddr_q     <= '0;
      load_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      disp_q      <= disp_d;
      load_prev_q <= load_i;
      // Write port registers change only on entry to WRITE and hold afterwards.
      if (state_q == StCollect && state_d == StWrite) begin
        wdata_q <= word_d;
        waddr_q <= addr_q;
      end
    end
  end

`ifdef RAM_WRITEBOARD_READBACK_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vphase_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      vphase_q <= (state_q == StVerify) && !vphase_q;
      if (state_q == StVerify && vphase_q) err_q <= (rdata_i != word_q);
    end
  end

  assign rden_o = (state_q == StVerify) && !vphase_q;
  assign err_o  = err_q;
`endif

  assign wren_o    = (state_q == StWrite);
  assign done_o    = (state_q == StDone);
  assign busy_o    = (state_q != StIdle);
  assign waddr_o   = waddr_q;
  assign wdata_o   = wdata_q;
  assign count_o   = count_q;
  assign display_o = disp_q;

endmodule

// File: doc/ram_writeboard.md
RAM_WRITEBOARD -- requirements
Module: ram_writeboard

Interface
REQ-001 Parameter D, default 8, address width (memory depth 2^D words).
REQ-002 Parameter W, default 32, word width; fixed at 32 (eight nibbles).
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, synchronous, active-low.
REQ-005 addr_i  input  D  target word address; sampled on the first accepted nibble.
REQ-006 nibble_i  input  4  data nibble from the board switches.
REQ-007 load_i  input  1  load button, level, already debounced; its rising edge is one load event.
REQ-008 abort_i  input  1  level; discards the word under assembly.
REQ-009 wren_o  output  1  memory write enable, one-cycle pulse.
REQ-010 waddr_o  output  D  write address, valid while wren_o=1.
REQ-011 wdata_o  output  W  assembled word, valid while wren_o=1.
REQ-012 count_o  output  3  index of the next nibble to load (0..7).
REQ-013 busy_o  output  1  high whenever the state is not IDLE.
REQ-014 done_o  output  1  one-cycle pulse when a write completes.
REQ-015 display_o  output  7  seven-segment code of the last loaded nibble, hex 0-F, order {g,f,e,d,c,b,a}, active-low.

Function
REQ-016 A load event shall be detected as load_i=1 in the current cycle and 0 in the previous registered cycle; a held button shall produce exactly one event.
REQ-017 FSM states shall be IDLE, COLLECT, WRITE, VERIFY (macro only) and DONE.
REQ-018 IDLE, on a load event: store nibble_i in word bits [3:0], latch addr_i, set count_o=1, and go to COLLECT.
REQ-019 COLLECT, on a load event with count k: store nibble_i in bits [4k+3:4k] and increment the count.
REQ-020 When the eighth nibble (k=7) is stored, count_o shall wrap to 0 and the next state shall be WRITE.
REQ-021 WRITE shall last exactly one cycle with wren_o=1, waddr_o=latched address and wdata_o=assembled word.
REQ-022 After WRITE, the next state shall be DONE, or VERIFY when the macro is enabled.
REQ-023 DONE shall last one cycle with done_o=1, then return to IDLE.
REQ-024 Latency from the eighth load event to wren_o shall be 1 cycle; to done_o it shall be 2 cycles (4 with the macro).
REQ-025 Load events in WRITE, VERIFY or DONE shall be ignored and not queued.
REQ-026 abort_i=1 in IDLE or COLLECT shall force IDLE with count_o=0 and the word cleared; abort shall win over a load event in the same cycle.
REQ-027 abort_i shall have no effect in WRITE, VERIFY or DONE; a started write always completes.
REQ-028 Changes on addr_i after the first nibble shall not affect waddr_o.
REQ-029 display_o shall update in the cycle following each accepted nibble and hold its value otherwise.
REQ-030 wdata_o and waddr_o shall hold their last values outside WRITE.

Reset
REQ-031 rst_ni=0 at a rising edge shall force IDLE, regardless of state, including mid-collection or mid-write.
REQ-032 Reset shall set count_o=0, the word=0, the latched address=0, wren_o=0, busy_o=0, done_o=0 and display_o=7'b1000000 ("0").
REQ-033 Reset shall set the edge-detect register to 1, so a button held through reset produces no event.
REQ-034 With the macro enabled, reset shall also set rden_o=0 and err_o=0.

Configuration
REQ-035 Macro RAM_WRITEBOARD_READBACK_EN shall, when defined, add the ports rden_o (output, 1), rdata_i (input, W) and err_o (output, 1), plus the VERIFY state.
REQ-036 With the macro, VERIFY shall take two cycles:
- cycle 1: rden_o=1 at the latched address;
- cycle 2: compare rdata_i with the word; err_o shall be set to 1 on mismatch and cleared to 0 on match, and held until the next compare or reset.
REQ-037 Without the macro, these ports and VERIFY shall not exist, and WRITE shall go directly to DONE.

Verification
REQ-038 Scenario, basic write: addr_i=8'h05, load nibbles 1,2,...,8 -> one wren_o pulse with waddr_o=8'h05 and wdata_o=32'h87654321; done_o pulses 1 cycle later.
REQ-039 Scenario, held button: load_i held high for 20 cycles -> count_o advances by exactly 1.
REQ-040 Scenario, abort: load 3 nibbles, then abort_i=1 in the same cycle as a load edge -> count_o=0, no wren_o, busy_o=0.
REQ-041 Scenario, mid-write events: eighth load, then a load edge during WRITE -> that edge is ignored and count_o=0 in IDLE.
REQ-042 Scenario, reset during collection: assert rst_ni=0 during COLLECT at count 5 -> all outputs at reset values and display_o=7'b1000000.
REQ-043 Scenario, readback (macro): rdata_i=32'hDEADBEEF against a written word of 32'h87654321 -> err_o=1 after VERIFY; a matching rdata_i -> err_o=0.
